// File: rtl/game_sequencer.sv
// Breakout game-flow controller: sequences serve/play/miss/win/over phases,
// tracks lives and a saturating score, and drives the ball's reset/run controls.
module game_sequencer #(
  parameter int START_LIVES  = 3,
  parameter int MISS_FRAMES  = 60,
  parameter int END_FRAMES   = 180,
  parameter int BRICK_POINTS = 10,
  parameter int SCORE_W      = 14
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               launch_btn,
  input  logic               brick_hit,
  input  logic               ball_missed,
  input  logic               all_cleared,
  output logic               ball_reset,
  output logic               ball_run,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         state,
  output logic               miss_sound
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_MISS  = 3'd3,
    S_WIN   = 3'd4,
    S_OVER  = 3'd5
  } state_e;

  localparam int MAX_FRAMES = (MISS_FRAMES > END_FRAMES) ? MISS_FRAMES : END_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

  localparam logic [CNT_W-1:0]   MISS_LAST = CNT_W'(MISS_FRAMES - 1);
  localparam logic [CNT_W-1:0]   END_LAST  = CNT_W'(END_FRAMES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               launch_prev_q, launch_prev_d;
  logic               ball_reset_q, ball_reset_d;
  logic               ball_run_q, ball_run_d;
  logic               miss_sound_q, miss_sound_d;

  logic               launch_edge;
  logic [SCORE_W:0]   score_sum;

  assign launch_edge = launch_btn && !launch_prev_q;
  assign score_sum   = {1'b0, score_q} + (SCORE_W + 1)'(BRICK_POINTS);

  // NOTE: every variable gets its default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lives_d       = lives_q;
    score_d       = score_q;
    launch_prev_d = launch_btn;
    miss_sound_d  = 1'b0;

    // The frame counter only ever advances up to its limit, so it cannot wrap.
    if (frame_tick && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (launch_edge) begin
          lives_d = 3'(START_LIVES);
          score_d = '0;
          state_d = S_SERVE;
        end
      end
      S_SERVE: begin
        if (launch_edge) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (brick_hit) score_d = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];
        if (all_cleared) begin
          state_d = S_WIN;
        end else if (ball_missed) begin
          state_d      = S_MISS;
          miss_sound_d = 1'b1;
          if (lives_q != 3'd0) lives_d = lives_q - 3'd1;
        end
      end
      S_MISS: begin
        if (frame_tick && cnt_q == MISS_LAST) state_d = (lives_q == 3'd0) ? S_OVER : S_SERVE;
      end
      S_WIN, S_OVER: begin
        if (frame_tick && cnt_q == END_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;

    // Ball controls are registered alongside the state so they switch together.
    ball_reset_d = (state_d == S_IDLE) || (state_d == S_SERVE);
    ball_run_d   = (state_d == S_PLAY);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      lives_q       <= 3'd0;
      score_q       <= '0;
      launch_prev_q <= 1'b1;
      ball_reset_q  <= 1'b1;
      ball_run_q    <= 1'b0;
      miss_sound_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lives_q       <= lives_d;
      score_q       <= score_d;
      launch_prev_q <= launch_prev_d;
      ball_reset_q  <= ball_reset_d;
      ball_run_q    <= ball_run_d;
      miss_sound_q  <= miss_sound_d;
    end
  end

  assign ball_reset = ball_reset_q;
  assign ball_run   = ball_run_q;
  assign lives      = lives_q;
  assign score      = score_q;
  assign state      = state_q;
  assign miss_sound = miss_sound_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: a directed vector table plus
// hand-written sequences for the frame-timed miss/end intervals and reset.
module tb_game_sequencer;

  logic clk = 1'b0;
  logic reset, frame_tick, launch_btn, brick_hit, ball_missed, all_cleared;

  logic        ball_reset, ball_run, miss_sound;
  logic [2:0]  lives, state;
  logic [13:0] score;

  logic        s_ball_reset, s_ball_run, s_miss_sound;
  logic [2:0]  s_lives, s_state;
  logic [5:0]  s_score;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  game_sequencer dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .launch_btn(launch_btn),
    .brick_hit(brick_hit), .ball_missed(ball_missed), .all_cleared(all_cleared),
    .ball_reset(ball_reset), .ball_run(ball_run), .lives(lives), .score(score),
    .state(state), .miss_sound(miss_sound)
  );

  // Narrow-score copy sharing the same stimulus, used for the saturation check.
  game_sequencer #(.SCORE_W(6)) dut_s (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .launch_btn(launch_btn),
    .brick_hit(brick_hit), .ball_missed(ball_missed), .all_cleared(all_cleared),
    .ball_reset(s_ball_reset), .ball_run(s_ball_run), .lives(s_lives), .score(s_score),
    .state(s_state), .miss_sound(s_miss_sound)
  );

  typedef struct {
    logic       launch, brick, missed, cleared;
    logic [2:0] st;
    logic [2:0] lv;
    int         sc;
    logic       run, brst, snd;
  } vec_t;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [2:0] st, input logic [2:0] lv,
                            input int sc, input logic run, input logic brst, input logic snd);
    check({tag, ".state"}, int'(state), int'(st));
    check({tag, ".lives"}, int'(lives), int'(lv));
    check({tag, ".score"}, int'(score), sc);
    check({tag, ".ball_run"}, int'(ball_run), int'(run));
    check({tag, ".ball_reset"}, int'(ball_reset), int'(brst));
    check({tag, ".miss_sound"}, int'(miss_sound), int'(snd));
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cycle();
      frame_tick = 1'b0;
      cycle();
    end
  endtask

  task automatic launch_pulse();
    launch_btn = 1'b1;
    cycle();
    launch_btn = 1'b0;
    cycle();
  endtask

  task automatic miss_once();
    ball_missed = 1'b1;
    cycle();
  endtask

  vec_t vecs[12];

  initial begin
    // launch, brick, missed, cleared -> state, lives, score, run, ball_reset, miss_sound
    vecs[0]  = '{0, 0, 0, 0, 3'd0, 3'd0,  0, 0, 1, 0};
    vecs[1]  = '{1, 0, 0, 0, 3'd1, 3'd3,  0, 0, 1, 0};
    vecs[2]  = '{0, 0, 0, 0, 3'd1, 3'd3,  0, 0, 1, 0};
    vecs[3]  = '{1, 0, 0, 0, 3'd2, 3'd3,  0, 1, 0, 0};
    vecs[4]  = '{0, 1, 0, 0, 3'd2, 3'd3, 10, 1, 0, 0};
    vecs[5]  = '{0, 1, 0, 0, 3'd2, 3'd3, 20, 1, 0, 0};
    vecs[6]  = '{0, 0, 0, 0, 3'd2, 3'd3, 20, 1, 0, 0};
    vecs[7]  = '{0, 1, 0, 0, 3'd2, 3'd3, 30, 1, 0, 0};
    vecs[8]  = '{1, 0, 0, 0, 3'd2, 3'd3, 30, 1, 0, 0};
    vecs[9]  = '{0, 1, 1, 1, 3'd4, 3'd3, 40, 0, 0, 0};
    vecs[10] = '{0, 1, 1, 1, 3'd4, 3'd3, 40, 0, 0, 0};
    vecs[11] = '{1, 0, 0, 0, 3'd4, 3'd3, 40, 0, 0, 0};

    frame_tick = 0; brick_hit = 0; ball_missed = 0; all_cleared = 0;
    launch_btn = 1'b1;
    reset = 1'b1;
    #12;
    check_outs("reset", 3'd0, 3'd0, 0, 0, 1, 0);

    // Button held across reset release must not count as a launch edge.
    @(negedge clk);
    reset = 1'b0;
    cycle(); cycle(); cycle();
    check("held_launch.state", int'(state), 0);
    launch_btn = 1'b0;
    cycle();

    for (int i = 0; i < 12; i++) begin
      launch_btn  = vecs[i].launch;
      brick_hit   = vecs[i].brick;
      ball_missed = vecs[i].missed;
      all_cleared = vecs[i].cleared;
      cycle();
      check_outs($sformatf("vec%0d", i), vecs[i].st, vecs[i].lv, vecs[i].sc,
                 vecs[i].run, vecs[i].brst, vecs[i].snd);
    end
    launch_btn = 0; brick_hit = 0; ball_missed = 0; all_cleared = 0;

    frames(179);
    check("win_179.state", int'(state), 4);
    frames(1);
    check_outs("win_done", 3'd0, 3'd3, 40, 0, 1, 0);

    // Fresh game, seven hits: wide score 70, narrow score saturated at 63.
    launch_pulse();
    check("new_game.score", int'(score), 0);
    launch_pulse();
    check("play2.state", int'(state), 2);
    brick_hit = 1'b1;
    for (int i = 0; i < 7; i++) cycle();
    brick_hit = 1'b0;
    check("sat.wide_score", int'(score), 70);
    check("sat.narrow_score", int'(s_score), 63);

    // First miss: one-cycle sound, 59 ticks stay in MISS, 60th re-serves.
    miss_once();
    check_outs("miss1", 3'd3, 3'd2, 70, 0, 0, 1);
    cycle();
    check("miss1.sound_off", int'(miss_sound), 0);
    check("miss1.held_state", int'(state), 3);
    ball_missed = 1'b0;
    frames(59);
    check("miss1_59.state", int'(state), 3);
    frames(1);
    check_outs("miss1_done", 3'd1, 3'd2, 70, 0, 1, 0);

    launch_pulse();
    miss_once();
    ball_missed = 1'b0;
    check("miss2.lives", int'(lives), 1);
    frames(60);
    check("miss2_done.state", int'(state), 1);

    launch_pulse();
    miss_once();
    ball_missed = 1'b0;
    check("miss3.lives", int'(lives), 0);
    frames(60);
    check_outs("over", 3'd5, 3'd0, 70, 0, 0, 0);
    frames(179);
    check("over_179.state", int'(state), 5);
    frames(1);
    check_outs("over_done", 3'd0, 3'd0, 70, 0, 1, 0);

    // Asynchronous reset mid-PLAY, applied away from any clock edge.
    launch_pulse();
    launch_pulse();
    brick_hit = 1'b1;
    cycle();
    brick_hit = 1'b0;
    check("pre_abort.state", int'(state), 2);
    #2;
    reset = 1'b1;
    #1;
    check_outs("abort", 3'd0, 3'd0, 0, 0, 1, 0);
    cycle();
    reset = 1'b0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
